// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA 640x480@60 timing generator with registered output stage
//
// Counts pixels (h_cnt) and lines (v_cnt), presents the visible coordinate to the
// pattern generator, samples its colour and drives registered rgb/hsync/vsync pins.
// Optional feature macro: VGA_CLKDIV_EN (clk_i at 50 MHz, one pixel every 2 clks).
//
// Ports:
//   clk_i          pixel clock (25 MHz, or 50 MHz with VGA_CLKDIV_EN)
//   rst_ni         asynchronous reset, active-low
//   rgb_i          {R,G,B} from pattern generator, combinational from row_o/column_o
//   row_o          visible line 0..V_ACTIVE-1, 0 outside the active area
//   column_o       visible pixel 0..H_ACTIVE-1, 0 outside the active area
//   vga_rgb_o      registered colour, 0 during blanking
//   hsync_o        registered horizontal sync, active-low
//   vsync_o        registered vertical sync, active-low
//   active_o       registered visible flag, aligned with vga_rgb_o
//   frame_start_o  registered one-clk pulse for pixel (0,0)

module vga_sync_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [2:0] rgb_i,
   output logic [8:0] row_o,
   output logic [9:0] column_o,
   output logic [2:0] vga_rgb_o,
   output logic       hsync_o,
   output logic       vsync_o,
   output logic       active_o,
   output logic       frame_start_o
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
   localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [9:0] h_cnt;
   logic [9:0] v_cnt;
   logic       tick;
   logic       vis;
   logic       hs_n;
   logic       vs_n;

`ifdef VGA_CLKDIV_EN
   // Toggling divider: low on the first clk after release, so the first pixel
   // advance lands on the second clk.
   logic div_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q <= 1'b0;
      end else begin
         div_q <= ~div_q;
      end
   end

   assign tick = div_q;
`else
   assign tick = 1'b1;
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
         end else begin
            h_cnt <= h_cnt + 10'd1;
         end
      end
   end

   assign vis      = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign row_o    = vis ? v_cnt[8:0] : '0;
   assign column_o = vis ? h_cnt : '0;
   assign hs_n     = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
   assign vs_n     = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

   // Output stage: one pixel of latency keeps every pin aligned with the
   // colour sampled for the same coordinate.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vga_rgb_o     <= '0;
         hsync_o       <= 1'b1;
         vsync_o       <= 1'b1;
         active_o      <= 1'b0;
         frame_start_o <= 1'b0;
      end else if (tick) begin
         vga_rgb_o     <= vis ? rgb_i : 3'b000;
         hsync_o       <= hs_n;
         vsync_o       <= vs_n;
         active_o      <= vis;
         frame_start_o <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
      end else begin
         // Pulse is one clk wide even when a pixel spans two clks.
         frame_start_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen

module tb_vga_sync_gen;

`ifdef VGA_CLKDIV_EN
   localparam int DIV = 2;
`else
   localparam int DIV = 1;
`endif
   // Vertical timing shortened so two whole frames fit in a short run;
   // horizontal timing keeps the 640x480 values.
   localparam int LINES = 13;
   localparam int VIS_LINES = 6;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [2:0] rgb_i;
   logic [8:0] row_o;
   logic [9:0] column_o;
   logic [2:0] vga_rgb_o;
   logic       hsync_o;
   logic       vsync_o;
   logic       active_o;
   logic       frame_start_o;

   vga_sync_gen #(
      .V_ACTIVE(6),
      .V_FP(2),
      .V_SYNC(2),
      .V_BP(3)
   ) dut (
      .clk_i(clk_i),
      .rst_ni(rst_ni),
      .rgb_i(rgb_i),
      .row_o(row_o),
      .column_o(column_o),
      .vga_rgb_o(vga_rgb_o),
      .hsync_o(hsync_o),
      .vsync_o(vsync_o),
      .active_o(active_o),
      .frame_start_o(frame_start_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {int cyc; int val;} ev_t;
   typedef struct {int cyc; int col; int row;} smp_t;

   ev_t   evq[5][$];
   smp_t  smpq[$];
   int    rstq[$];
   string sig_name[5] = '{"hsync", "vsync", "frame_start", "active", "vga_rgb"};

   int n_checks = 0;
   int n_errors = 0;
   int cyc;
   int prev[5];
   int cur[5];
   ev_t  e;
   smp_t m;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // clks since reset release
   always @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   // Monitor: every level change of a registered pin pops that pin's queue.
   always @(negedge clk_i) begin
      cur[0] = int'(hsync_o);
      cur[1] = int'(vsync_o);
      cur[2] = int'(frame_start_o);
      cur[3] = int'(active_o);
      cur[4] = int'(vga_rgb_o);
      if (!rst_ni) begin
         if (rstq.size() > 0) begin
            void'(rstq.pop_front());
            check("reset hsync", int'(hsync_o), 1);
            check("reset vsync", int'(vsync_o), 1);
            check("reset vga_rgb", int'(vga_rgb_o), 0);
            check("reset active", int'(active_o), 0);
            check("reset frame_start", int'(frame_start_o), 0);
            check("reset row", int'(row_o), 0);
            check("reset column", int'(column_o), 0);
         end
      end else begin
         for (int s = 0; s < 5; s++) begin
            if (cur[s] != prev[s]) begin
               if (evq[s].size() == 0) begin
                  check({sig_name[s], " unexpected edge at cyc"}, cyc, -1);
               end else begin
                  e = evq[s].pop_front();
                  check({sig_name[s], " edge cyc"}, cyc, e.cyc);
                  check({sig_name[s], " edge value"}, cur[s], e.val);
               end
            end
         end
         if (smpq.size() > 0 && smpq[0].cyc <= cyc) begin
            m = smpq.pop_front();
            check("sample cyc", cyc, m.cyc);
            check("column", int'(column_o), m.col);
            check("row", int'(row_o), m.row);
         end
      end
      prev = cur;
   end

   task automatic push_ev(input int s, input int c, input int v, input int lim);
      if (c <= lim) evq[s].push_back('{c, v});
   endtask

   // pixel n after release: column/row seen at clk DIV*n
   task automatic push_smp(input int n, input int col, input int row);
      smpq.push_back('{DIV * n, col, row});
   endtask

   // Expected pin edges for npix pixels after release. Output for pixel p-1
   // appears on clk DIV*p: hsync low for h 656..751, active for h 0..639 on
   // visible lines, vsync low on lines 8..9, frame_start on pixel 0 of line 0.
   task automatic push_run(input int npix, input int rgbv);
      int lim;
      lim = DIV * npix;
      for (int l = 0; l * 800 < npix; l++) begin
         int b;
         int lv;
         b  = l * 800;
         lv = l % LINES;
         push_ev(0, DIV * (b + 657), 0, lim);
         push_ev(0, DIV * (b + 753), 1, lim);
         if (lv < VIS_LINES) begin
            push_ev(3, DIV * (b + 1), 1, lim);
            push_ev(3, DIV * (b + 641), 0, lim);
            push_ev(4, DIV * (b + 1), rgbv, lim);
            push_ev(4, DIV * (b + 641), 0, lim);
         end
         if (lv == 0) begin
            push_ev(2, DIV * (b + 1), 1, lim);
            push_ev(2, DIV * (b + 1) + 1, 0, lim);
         end
         if (lv == 8)  push_ev(1, DIV * (b + 1), 0, lim);
         if (lv == 10) push_ev(1, DIV * (b + 1), 1, lim);
      end
   endtask

   task automatic run_to(input int target);
      int n;
      n = 0;
      while (cyc != target && n < target + 200) begin
         @(negedge clk_i);
         n++;
      end
      check("reached cycle", cyc, target);
      #2;
      for (int s = 0; s < 5; s++) begin
         check({sig_name[s], " pending events"}, evq[s].size(), 0);
         evq[s].delete();
      end
      check("pending samples", smpq.size(), 0);
      smpq.delete();
   endtask

   initial begin
      rst_ni = 1'b0;
      rgb_i  = 3'b000;
      rstq.push_back(1);
      repeat (3) @(negedge clk_i);

      // line timing up to h=300,v=3
      rgb_i = 3'b100;
      push_run(2700, 4);
      push_smp(1, 1, 0);
      push_smp(639, 639, 0);
      push_smp(640, 0, 0);
      push_smp(805, 5, 1);
      push_smp(2700, 300, 3);
      #1 rst_ni = 1'b1;
      run_to(DIV * 2700);

      // reset mid-line, asserted just after a clk edge
      rstq.push_back(1);
      @(posedge clk_i);
      #1 rst_ni = 1'b0;
      repeat (2) @(negedge clk_i);

      rgb_i = 3'b011;
      push_run(1000, 3);
      push_smp(1, 1, 0);
      push_smp(2, 2, 0);
      push_smp(3, 3, 0);
      push_smp(801, 1, 1);
      #1 rst_ni = 1'b1;
      run_to(DIV * 1000);

      // two full frames
      rst_ni = 1'b0;
      rstq.push_back(1);
      repeat (2) @(negedge clk_i);
      rgb_i = 3'b100;
      push_run(20800, 4);
      push_smp(1, 1, 0);
      push_smp(639, 639, 0);
      push_smp(640, 0, 0);
      push_smp(799, 0, 0);
      push_smp(800, 0, 1);
      push_smp(4639, 639, 5);
      push_smp(4800, 0, 0);
      push_smp(10400, 0, 0);
      push_smp(11201, 1, 1);
      push_smp(14500, 100, 5);
      #1 rst_ni = 1'b1;
      run_to(DIV * 20800);

      check("reset checks consumed", rstq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
